// File: rtl/branch_resolve_if.sv
// Handshake/bus bundle between EX, the branch resolve unit and the fetch PC mux.
// The slave modport is the resolve unit; the master modport is the EX/fetch side.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_is_jump;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_jump_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            alu_zero;
  logic            alu_negative;
  logic            alu_overflow;
  logic            alu_carry;
  logic            redirect_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            ex_stall;
  logic            illegal_cond;

  modport slave (
    input  ex_valid, ex_is_jump, ex_funct3, ex_pc, ex_imm, ex_jump_target,
           ex_pred_taken, ex_pred_target, alu_zero, alu_negative,
           alu_overflow, alu_carry, redirect_ready,
    output redirect_valid, redirect_pc, flush, ex_stall, illegal_cond
  );

  modport master (
    output ex_valid, ex_is_jump, ex_funct3, ex_pc, ex_imm, ex_jump_target,
           ex_pred_taken, ex_pred_target, alu_zero, alu_negative,
           alu_overflow, alu_carry, redirect_ready,
    input  redirect_valid, redirect_pc, flush, ex_stall, illegal_cond
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches/jumps from ALU subtract flags and requests a fetch redirect on mispredict.
// Optional statistics counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN = 32
`ifdef BRANCH_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_if.slave        bus
`ifdef BRANCH_STATS_EN
  , output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]      stat_taken,
  output logic [STAT_W-1:0]      stat_mispredicts
`endif
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state;
  logic            redirect_valid_q;
  logic            ex_stall_q;
  logic            illegal_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            illegal;
  logic            actual_taken;
  logic [XLEN-1:0] taken_target;
  logic [XLEN-1:0] fall_through;
  logic [XLEN-1:0] correct_pc;
  logic            mispredict;
  logic            accept;

  function automatic logic cond_taken(input logic [2:0] f3, input logic z,
                                      input logic n, input logic v, input logic c);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n ^ v;
      3'b101:  return !(n ^ v);
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

`ifdef BRANCH_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction
`endif

  always_comb begin
    illegal      = !bus.ex_is_jump && (bus.ex_funct3[2:1] == 2'b01);
    actual_taken = bus.ex_is_jump ||
                   cond_taken(bus.ex_funct3, bus.alu_zero, bus.alu_negative,
                              bus.alu_overflow, bus.alu_carry);
    taken_target = bus.ex_is_jump ? bus.ex_jump_target : bus.ex_pc + bus.ex_imm;
    fall_through = bus.ex_pc + XLEN'(4);
    correct_pc   = actual_taken ? taken_target : fall_through;
    mispredict   = !illegal &&
                   ((actual_taken != bus.ex_pred_taken) ||
                    (actual_taken && (taken_target != bus.ex_pred_target)));
    accept       = (state == IDLE) && bus.ex_valid;
  end

  // EX inputs are only sampled in IDLE; REDIRECT waits solely on the fetch handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      redirect_valid_q <= 1'b0;
      ex_stall_q       <= 1'b0;
      illegal_q        <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              illegal_q <= 1'b1;
            end else if (mispredict) begin
              redirect_pc_q    <= correct_pc;
              redirect_valid_q <= 1'b1;
              ex_stall_q       <= 1'b1;
              state            <= REDIRECT;
            end
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            ex_stall_q       <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.ex_stall       = ex_stall_q;
  assign bus.illegal_cond   = illegal_q;
  assign bus.flush          = redirect_valid_q & bus.redirect_ready;

`ifdef BRANCH_STATS_EN
  // Illegal conditions count as accepted, not-taken, and never as mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_taken       <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      stat_branches <= sat_inc(stat_branches);
      if (actual_taken && !illegal) stat_taken <= sat_inc(stat_taken);
      if (mispredict) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus multi-cycle handshake/reset sequences.
// Stats checks are compiled only when BRANCH_STATS_EN is defined (counters built 2 bits wide to reach saturation).
module tb_branch_resolve_unit;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  branch_resolve_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
  logic [1:0] stat_branches, stat_taken, stat_mispredicts;
  branch_resolve_unit #(.XLEN(XLEN), .STAT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .stat_branches(stat_branches), .stat_taken(stat_taken),
    .stat_mispredicts(stat_mispredicts)
  );
`else
  branch_resolve_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_jump;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] jt;
    logic        pt;
    logic [31:0] ptgt;
    logic [3:0]  znvc;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic is_jump, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] jt, input logic pt,
                        input logic [31:0] ptgt, input logic [3:0] znvc);
    bus.ex_valid       = 1'b1;
    bus.ex_is_jump     = is_jump;
    bus.ex_funct3      = f3;
    bus.ex_pc          = pc;
    bus.ex_imm         = imm;
    bus.ex_jump_target = jt;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
    {bus.alu_zero, bus.alu_negative, bus.alu_overflow, bus.alu_carry} = znvc;
  endtask

  // Present one instruction for one edge; caller is positioned at a falling edge.
  task automatic issue(input logic is_jump, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] jt, input logic pt,
                       input logic [31:0] ptgt, input logic [3:0] znvc);
    set_ex(is_jump, f3, pc, imm, jt, pt, ptgt, znvc);
    @(negedge clk);
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_is_jump = 1'b0;
    bus.ex_funct3 = 3'b000;
    bus.ex_pc = '0;
    bus.ex_imm = '0;
    bus.ex_jump_target = '0;
    bus.ex_pred_taken = 1'b0;
    bus.ex_pred_target = '0;
    {bus.alu_zero, bus.alu_negative, bus.alu_overflow, bus.alu_carry} = 4'b0000;
    bus.redirect_ready = 1'b1;

    //          jmp  f3      pc            imm         jt          pt  ptgt        ZNVC     redir pc           ill
    vecs[0]  = '{1'b0, 3'b000, 32'h100,      32'h20,      32'h0,   1'b0, 32'h120,  4'b1000, 1'b1, 32'h120,      1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h100,      32'h20,      32'h0,   1'b0, 32'h120,  4'b0000, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 3'b001, 32'h100,      32'h20,      32'h0,   1'b1, 32'h120,  4'b0000, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h100,      32'h20,      32'h0,   1'b1, 32'h120,  4'b1000, 1'b1, 32'h104,      1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'h100,      32'h20,      32'h0,   1'b0, 32'h120,  4'b0100, 1'b1, 32'h120,      1'b0};
    vecs[5]  = '{1'b0, 3'b101, 32'h100,      32'h20,      32'h0,   1'b0, 32'h120,  4'b0110, 1'b1, 32'h120,      1'b0};
    vecs[6]  = '{1'b0, 3'b110, 32'h100,      32'h20,      32'h0,   1'b1, 32'h120,  4'b0000, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 3'b111, 32'h100,      32'h20,      32'h0,   1'b1, 32'h120,  4'b0000, 1'b1, 32'h104,      1'b0};
    vecs[8]  = '{1'b0, 3'b111, 32'h100,      32'h20,      32'h0,   1'b1, 32'h124,  4'b0001, 1'b1, 32'h120,      1'b0};
    vecs[9]  = '{1'b1, 3'b000, 32'h100,      32'h20,      32'h204, 1'b1, 32'h200,  4'b1111, 1'b1, 32'h204,      1'b0};
    vecs[10] = '{1'b1, 3'b000, 32'h100,      32'h20,      32'h300, 1'b0, 32'h0,    4'b0000, 1'b1, 32'h300,      1'b0};
    vecs[11] = '{1'b1, 3'b000, 32'h100,      32'h20,      32'h300, 1'b1, 32'h300,  4'b0000, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 3'b000, 32'hFFFFFFFC, 32'h20,      32'h0,   1'b1, 32'h10,   4'b0000, 1'b1, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 3'b000, 32'hFFFFFFF0, 32'h20,      32'h0,   1'b0, 32'h0,    4'b1000, 1'b1, 32'h00000010, 1'b0};
    vecs[14] = '{1'b0, 3'b010, 32'h100,      32'h20,      32'h0,   1'b1, 32'h120,  4'b0000, 1'b0, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 3'b011, 32'h100,      32'h20,      32'h0,   1'b0, 32'h120,  4'b1000, 1'b0, 32'h0,        1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc",    bus.redirect_pc,         32'd0);
    chk("rst_flush",          32'(bus.flush),          32'd0);
    chk("rst_ex_stall",       32'(bus.ex_stall),       32'd0);
    chk("rst_illegal",        32'(bus.illegal_cond),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: each vector resolves with redirect_ready high, so any redirect is single-cycle
    for (int i = 0; i < 16; i++) begin
      bus.redirect_ready = 1'b1;
      issue(vecs[i].is_jump, vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].jt,
            vecs[i].pt, vecs[i].ptgt, vecs[i].znvc);
      chk($sformatf("v%0d_redirect_valid", i), 32'(bus.redirect_valid), 32'(vecs[i].exp_redir));
      chk($sformatf("v%0d_flush", i),          32'(bus.flush),          32'(vecs[i].exp_redir));
      chk($sformatf("v%0d_ex_stall", i),       32'(bus.ex_stall),       32'(vecs[i].exp_redir));
      chk($sformatf("v%0d_illegal", i),        32'(bus.illegal_cond),   32'(vecs[i].exp_ill));
      if (vecs[i].exp_redir)
        chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].exp_pc);
      @(negedge clk);
      chk($sformatf("v%0d_idle_valid", i),   32'(bus.redirect_valid), 32'd0);
      chk($sformatf("v%0d_idle_flush", i),   32'(bus.flush),          32'd0);
      chk($sformatf("v%0d_illegal_off", i),  32'(bus.illegal_cond),   32'd0);
    end

    // BLT not-less with ready held low: request holds, EX traffic ignored
    bus.redirect_ready = 1'b0;
    issue(1'b0, 3'b100, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 4'b0110);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), 32'(bus.redirect_valid), 32'd1);
      chk($sformatf("hold%0d_stall", k), 32'(bus.ex_stall),       32'd1);
      chk($sformatf("hold%0d_pc", k),    bus.redirect_pc,         32'h104);
      chk($sformatf("hold%0d_flush", k), 32'(bus.flush),          32'd0);
      set_ex(1'b1, 3'b000, 32'h500, 32'h0, 32'h900, 1'b0, 32'h0, 4'b1111);
      @(negedge clk);
    end
    bus.ex_valid = 1'b0;
    chk("hold_pc_after_ex", bus.redirect_pc, 32'h104);
    bus.redirect_ready = 1'b1;
    #1;
    chk("hs_flush_comb", 32'(bus.flush), 32'd1);
    @(negedge clk);
    chk("hs_valid_drop", 32'(bus.redirect_valid), 32'd0);
    chk("hs_flush_once", 32'(bus.flush),          32'd0);
    // Back-to-back: mispredict in the first IDLE cycle after the handshake
    bus.redirect_ready = 1'b0;
    issue(1'b0, 3'b000, 32'h200, 32'h40, 32'h0, 1'b0, 32'h0, 4'b1000);
    chk("b2b_valid", 32'(bus.redirect_valid), 32'd1);
    chk("b2b_pc",    bus.redirect_pc,         32'h240);

    // Asynchronous reset mid-REDIRECT: request dropped without a flush
    bus.redirect_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.redirect_valid), 32'd0);
    chk("arst_flush", 32'(bus.flush),          32'd0);
    chk("arst_stall", 32'(bus.ex_stall),       32'd0);
    chk("arst_pc",    bus.redirect_pc,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.redirect_valid), 32'd0);

`ifdef BRANCH_STATS_EN
    // Fresh counters: 3 branches, 2 taken, 1 mispredict, then 2 more to saturate branches
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 4'b1000);
    issue(1'b0, 3'b001, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 4'b0000);
    issue(1'b0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 4'b0000);
    @(negedge clk);
    chk("stat_branches", 32'(stat_branches),    32'd3);
    chk("stat_taken",    32'(stat_taken),       32'd2);
    chk("stat_mispred",  32'(stat_mispredicts), 32'd1);
    issue(1'b0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0, 4'b0000);
    issue(1'b0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0, 4'b0000);
    chk("stat_branches_sat", 32'(stat_branches),    32'd3);
    chk("stat_taken_hold",   32'(stat_taken),       32'd2);
    chk("stat_mispred_hold", 32'(stat_mispredicts), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the ALU subtract flags (Zero, Negative, OverFlow, Carry) for a resolving branch or jump in EX.
- Decides the actual direction and compares it against the fetch prediction.
- On a mispredict, holds a redirect request to fetch under a valid/ready handshake and pulses a pipeline flush.
- Sits between the EX stage and the fetch PC mux.

Parameters:
- XLEN, 32, width of PC, immediate and target buses.
- STAT_W, 32, width of each statistics counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a control-flow instruction to resolve this cycle.
- ex_is_jump  in  1  1 = JAL/JALR (always taken); 0 = conditional branch.
- ex_funct3  in  3  branch condition code.
- ex_pc  in  XLEN  PC of the instruction.
- ex_imm  in  XLEN  sign-extended branch offset.
- ex_jump_target  in  XLEN  jump target computed by EX (bit0 already cleared).
- ex_pred_taken  in  1  fetch predicted taken.
- ex_pred_target  in  XLEN  fetch predicted target.
- alu_zero, alu_negative, alu_overflow, alu_carry  in  1 each  ALU flags for rs1 - rs2 (subtract operation).
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_valid  out  1  redirect request pending.
- redirect_pc  out  XLEN  corrected fetch PC.
- flush  out  1  one-cycle pulse: kill IF/ID younger instructions.
- ex_stall  out  1  EX must hold; the unit is busy.
- illegal_cond  out  1  one-cycle pulse: funct3 is 010 or 011 on a branch.

Behaviour:
- Reset: all outputs 0, FSM state = IDLE, internal registers 0; asynchronous on rst_n low; release is synchronous to clk.
- Condition decode (branch only, from flags):
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N^V
  - 101 BGE: !(N^V)
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010/011: not taken, illegal_cond pulses next cycle, no redirect.
- Jumps are always taken; their flags are ignored.
- Targets:
  - Branch taken target = ex_pc + ex_imm, modulo 2^XLEN (wraps, no trap).
  - Jump target = ex_jump_target.
  - Fall-through = ex_pc + 4, also wrapping.
- Mispredict: actual_taken != ex_pred_taken, or both taken with actual target != ex_pred_target.
- Correct PC: target if taken, else fall-through.
- FSM states IDLE and REDIRECT:
  - IDLE + ex_valid + mispredict: register correct PC into redirect_pc; next cycle state = REDIRECT with redirect_valid=1. Latency is exactly 1 cycle.
  - IDLE + ex_valid + correct prediction: stay in IDLE, no outputs.
  - REDIRECT: redirect_valid=1 and ex_stall=1; redirect_pc stays stable until handshake. ex_valid is ignored because EX holds.
  - Handshake (redirect_valid & redirect_ready on a rising edge): flush=1 for that same cycle (combinational on the handshake); next state = IDLE with redirect_valid=0.
  - redirect_ready high on the very first REDIRECT cycle: single-cycle redirect, flush pulses in that cycle.
  - redirect_ready held low indefinitely: remain in REDIRECT; no timeout.
- Back-to-back: a mispredict arriving in the cycle after returning to IDLE is accepted normally. No instruction is lost because ex_stall was high while busy.
- rst_n asserted mid-REDIRECT: request dropped, redirect_valid=0 immediately, no flush pulse.
- ex_valid with unknown flags while in REDIRECT must not disturb any state.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds outputs stat_branches, stat_taken, stat_mispredicts, each STAT_W bits.
  - These count, respectively: accepted ex_valid events (IDLE only), actually-taken events, and mispredict events.
  - Counters saturate at all-ones and reset to 0.
- When undefined, the ports and counters do not exist; core behaviour is identical.

Test Plan:
- BEQ, Z=1, pred_taken=0, pc=0x100, imm=0x20 -> next cycle redirect_valid=1, redirect_pc=0x120; with redirect_ready=1, flush pulses once and the FSM returns to IDLE.
- BLT with N=1, V=1 (not less), pred_taken=1 -> redirect_pc=pc+4=0x104; with ready held low for 5 cycles, redirect_valid and ex_stall stay high and redirect_pc is stable.
- BLTU, C=0, pred_taken=1, pred_target=0x120, pc=0x100, imm=0x20 -> no redirect, no flush, ex_stall stays 0.
- Jump with pred_taken=1, pred_target=0x200, ex_jump_target=0x204 -> redirect_pc=0x204; pc=0xFFFFFFFC branch not-taken mispredict -> redirect_pc=0x00000000 (wrap).
- funct3=010 -> illegal_cond pulses once, no redirect; assert rst_n low while in REDIRECT -> redirect_valid drops asynchronously, no flush pulse.
- With BRANCH_STATS_EN: 3 branches, 2 taken, 1 mispredict -> counters read 3/2/1; preload near saturation and confirm the counter stays at 0xFFFFFFFF.
